// File: rtl/eaglesong_circulant.sv
// Eaglesong circulant step: out = rotl(w,c0) ^ rotl(w,c1) ^ rotl(w,c2), one rotation per cycle.
// The rotation amounts come from the combinational coefficient table, indexed by 3*word_idx + k.

module eaglesong_coefficients (
  input  logic [5:0] index_to_request,
  output logic [4:0] coefficient
);

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    coefficient = 5'd0;
    case (index_to_request)
      6'd0:  coefficient = 5'd0;   6'd1:  coefficient = 5'd2;   6'd2:  coefficient = 5'd4;
      6'd3:  coefficient = 5'd0;   6'd4:  coefficient = 5'd13;  6'd5:  coefficient = 5'd22;
      6'd6:  coefficient = 5'd0;   6'd7:  coefficient = 5'd4;   6'd8:  coefficient = 5'd19;
      6'd9:  coefficient = 5'd0;   6'd10: coefficient = 5'd3;   6'd11: coefficient = 5'd14;
      6'd12: coefficient = 5'd0;   6'd13: coefficient = 5'd27;  6'd14: coefficient = 5'd31;
      6'd15: coefficient = 5'd0;   6'd16: coefficient = 5'd3;   6'd17: coefficient = 5'd8;
      6'd18: coefficient = 5'd0;   6'd19: coefficient = 5'd17;  6'd20: coefficient = 5'd26;
      6'd21: coefficient = 5'd0;   6'd22: coefficient = 5'd3;   6'd23: coefficient = 5'd12;
      6'd24: coefficient = 5'd0;   6'd25: coefficient = 5'd18;  6'd26: coefficient = 5'd22;
      6'd27: coefficient = 5'd0;   6'd28: coefficient = 5'd12;  6'd29: coefficient = 5'd18;
      6'd30: coefficient = 5'd0;   6'd31: coefficient = 5'd4;   6'd32: coefficient = 5'd7;
      6'd33: coefficient = 5'd0;   6'd34: coefficient = 5'd4;   6'd35: coefficient = 5'd31;
      6'd36: coefficient = 5'd0;   6'd37: coefficient = 5'd12;  6'd38: coefficient = 5'd27;
      6'd39: coefficient = 5'd0;   6'd40: coefficient = 5'd7;   6'd41: coefficient = 5'd17;
      6'd42: coefficient = 5'd0;   6'd43: coefficient = 5'd7;   6'd44: coefficient = 5'd8;
      6'd45: coefficient = 5'd0;   6'd46: coefficient = 5'd1;   6'd47: coefficient = 5'd13;
      default: coefficient = 5'd0;
    endcase
  end

endmodule

module eaglesong_circulant #(
  parameter int WORDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic        out_last,
  output logic [3:0]  word_idx
);

  localparam logic [3:0] LAST_IDX = 4'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, ROT, OUT} state_e;

  state_e      state_q;
  logic [1:0]  k_q;
  logic [3:0]  word_idx_q, word_idx_d;
  logic [31:0] word_q, acc_q, acc_d;
  logic        in_ready_q, out_valid_q, out_last_q;

  logic [5:0]  coef_index;
  logic [4:0]  coef;
  logic [31:0] rotated;

  assign coef_index = 6'd3 * {2'b00, word_idx_q} + {4'b0000, k_q};

  eaglesong_coefficients u_coefficients (
    .index_to_request (coef_index),
    .coefficient      (coef)
  );

  // A right shift by 32 yields zero, so a zero rotation returns the word unchanged.
  assign rotated    = (word_q << coef) | (word_q >> (6'd32 - {1'b0, coef}));
  assign acc_d      = acc_q ^ rotated;
  assign word_idx_d = (word_idx_q == LAST_IDX) ? 4'd0 : word_idx_q + 4'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      word_idx_q  <= 4'd0;
      word_q      <= 32'd0;
      acc_q       <= 32'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            word_q     <= in_word;
            acc_q      <= 32'd0;
            k_q        <= 2'd0;
            in_ready_q <= 1'b0;
            state_q    <= ROT;
          end
        end
        ROT: begin
          acc_q <= acc_d;
          if (k_q == 2'd2) begin
            out_valid_q <= 1'b1;
            out_last_q  <= (word_idx_q == LAST_IDX);
            state_q     <= OUT;
          end else begin
            k_q <= k_q + 2'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            word_idx_q  <= word_idx_d;
            k_q         <= 2'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_word  = acc_q;
  assign out_last  = out_last_q;
  assign word_idx  = word_idx_q;

endmodule

// File: tb/tb_eaglesong_circulant.sv
// Bench for eaglesong_circulant: a cycle-level behavioural model checked every cycle,
// plus hand-computed literal expectations for the directed vectors.

module tb_eaglesong_circulant;

  localparam int WORDS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_word;
  logic        out_last;
  logic [3:0]  word_idx;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  eaglesong_circulant #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_last  (out_last),
    .word_idx  (word_idx)
  );

  always #5 clk = ~clk;

  int coef_tbl [48] = '{0, 2, 4, 0, 13, 22, 0, 4, 19, 0, 3, 14, 0, 27, 31, 0, 3, 8,
                        0, 17, 26, 0, 3, 12, 0, 18, 22, 0, 12, 18, 0, 4, 7, 0, 4, 31,
                        0, 12, 27, 0, 7, 17, 0, 7, 8, 0, 1, 13};

  function automatic logic [31:0] circ(input logic [31:0] w, input int idx);
    logic [31:0] r;
    int c;
    r = 32'd0;
    for (int k = 0; k < 3; k++) begin
      c = coef_tbl[3 * idx + k];
      if (c == 0) r = r ^ w;
      else        r = r ^ ((w << c) | (w >> (32 - c)));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 = waiting for a word, 1..3 = rotating, 4 = presenting the result.
  int          m_phase = 0;
  int          m_idx = 0;
  logic [31:0] m_res = 32'd0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0;
      m_idx   <= 0;
      m_res   <= 32'd0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        m_phase <= 1;
        m_res   <= circ(in_word, m_idx);
      end
    end else if (m_phase < 4) begin
      m_phase <= m_phase + 1;
    end else if (out_ready) begin
      m_phase <= 0;
      m_idx   <= (m_idx + 1) % WORDS;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_in_ready", {31'd0, in_ready}, {31'd0, m_phase == 0});
      check("model_out_valid", {31'd0, out_valid}, {31'd0, m_phase == 4});
      check("model_word_idx", {28'd0, word_idx}, 32'(m_idx));
      if (m_phase == 4) begin
        check("model_out_word", out_word, m_res);
        check("model_out_last", {31'd0, out_last}, {31'd0, m_idx == WORDS - 1});
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_word  = w;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic do_word(input logic [31:0] w, output logic [31:0] got,
                         output logic got_last, output int lat);
    send(w);
    wait_out(lat);
    got      = out_word;
    got_last = out_last;
    @(negedge clk);
  endtask

  logic [31:0] stim [16] = '{32'h0000_0001, 32'h0000_0001, 32'h1234_5678, 32'hDEAD_BEEF,
                             32'h0000_0001, 32'hA5A5_A5A5, 32'h0F0F_0001, 32'h8000_0001,
                             32'h7654_3210, 32'h0000_FFFF, 32'hFFFF_0000, 32'h1357_9BDF,
                             32'h2468_ACE0, 32'h0000_0100, 32'hC001_D00D, 32'h8000_0000};

  initial begin
    logic [31:0] got;
    logic        got_last;
    int          lat;

    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_word", out_word, 32'd0);
    check("reset_out_last", {31'd0, out_last}, 32'd0);
    check("reset_word_idx", {28'd0, word_idx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full round with no backpressure; out_ready is already high before any output.
    for (int i = 0; i < 16; i++) begin
      do_word(stim[i], got, got_last, lat);
      if (i == 0) begin
        check("w0_out_word", got, 32'h0000_0015);
        check("w0_out_last", {31'd0, got_last}, 32'd0);
        check("w0_latency", 32'(lat), 32'd4);
        check("w0_next_idx", {28'd0, word_idx}, 32'd1);
      end
      if (i == 1) check("w1_out_word", got, 32'h0040_2001);
      if (i == 4) check("w4_out_word", got, 32'h8800_0001);
      if (i == 15) begin
        check("w15_out_word", got, 32'h8000_1001);
        check("w15_out_last", {31'd0, got_last}, 32'd1);
      end
    end
    check("wrap_word_idx", {28'd0, word_idx}, 32'd0);

    // Backpressure: result held for 10 cycles while a competing word is offered.
    out_ready = 1'b0;
    send(32'hFFFF_FFFF);
    wait_out(lat);
    check("bp_out_word", out_word, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_word  = 32'h0BAD_0BAD;
      @(negedge clk);
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_word", out_word, 32'hFFFF_FFFF);
      check("bp_hold_idx", {28'd0, word_idx}, 32'd0);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_idx", {28'd0, word_idx}, 32'd1);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);

    // Reset during the second rotation cycle of word 3.
    do_word(32'h0000_0003, got, got_last, lat);
    do_word(32'h0000_0005, got, got_last, lat);
    in_valid = 1'b1;
    in_word  = 32'h1111_2222;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rot_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rot_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rot_rst_word_idx", {28'd0, word_idx}, 32'd0);
    do_word(32'h0000_0001, got, got_last, lat);
    check("rot_rst_next_word", got, 32'h0000_0015);

    // Reset during OUT, with in_valid and out_ready asserted on the same edge.
    out_ready = 1'b0;
    send(32'hCAFE_F00D);
    wait_out(lat);
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_word   = 32'h0000_0001;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("out_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("out_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("out_rst_out_word", out_word, 32'd0);
    check("out_rst_out_last", {31'd0, out_last}, 32'd0);
    check("out_rst_word_idx", {28'd0, word_idx}, 32'd0);

    // Reset together with in_valid while idle: nothing is accepted.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_word  = 32'h0000_0001;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("idle_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("idle_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_rst_word_idx", {28'd0, word_idx}, 32'd0);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
